// File: rtl/fetch_queue.sv
// fetch_queue: issues line-sized read bursts on the Sysbus, unpacks each beat
// into 32-bit instructions and buffers them with their PCs for decode.
module fetch_queue #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned LINE_BYTES     = 64,
    parameter int unsigned QUEUE_DEPTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [31:0]               inst_bits,
    output logic [63:0]               inst_pc,
    input  logic                      redirect,
    input  logic [63:0]               redirect_pc,
    output logic                      halted
);
    localparam int unsigned BEATS         = LINE_BYTES * 8 / BUS_DATA_WIDTH;
    localparam int unsigned WPB           = BUS_DATA_WIDTH / 32;
    localparam int unsigned BEAT_BYTES    = BUS_DATA_WIDTH / 8;
    localparam int unsigned IPL           = LINE_BYTES / 4;
    localparam int unsigned PTR_W         = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W         = PTR_W + 1;
    localparam int unsigned BEAT_W        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W         = $clog2(LINE_BYTES);
    localparam int unsigned SYSBUS_READ   = 1;
    localparam int unsigned SYSBUS_MEMORY = 1;
    localparam int unsigned REQ_TAG       = (SYSBUS_READ << 12) | (SYSBUS_MEMORY << 8);

    typedef enum logic [2:0] {IDLE, REQ, RESP, DRAIN, HALT} state_t;

    state_t              state;
    state_t              state_nx;
    logic [63:0]         fetch_pc;
    logic [BEAT_W-1:0]   beat;
    logic                halt_pend;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [31:0]         mem_bits [QUEUE_DEPTH];
    logic [63:0]         mem_pc   [QUEUE_DEPTH];

    logic [63:0]         line_base;
    logic [CNT_W-1:0]    free_slots;
    logic                beat_last;
    logic                beat_fire;
    logic                take;
    logic                deq;
    logic                zero_hit;
    logic [CNT_W-1:0]    n_enq;
    logic [WPB-1:0]      word_en;
    logic [PTR_W-1:0]    word_off  [WPB];
    logic [63:0]         word_addr [WPB];
    logic                unused_tag;

    assign unused_tag = ^bus_resptag;
    assign bus_reqtag = BUS_TAG_WIDTH'(REQ_TAG);
    assign line_base  = {fetch_pc[63:OFF_W], OFF_W'(0)};
    assign free_slots = CNT_W'(QUEUE_DEPTH) - count;
    assign beat_last  = (beat == BEAT_W'(BEATS - 1));
    assign beat_fire  = ((state == RESP) || (state == DRAIN)) && bus_respcyc;
    assign take       = (state == RESP) && bus_respcyc && !redirect && !reset;
    assign deq        = inst_valid && inst_ready;

    // Split the beat into words: skip those below fetch_pc, stop at a zero word.
    always_comb begin
        n_enq    = '0;
        zero_hit = 1'b0;
        word_en  = '0;
        for (int k = 0; k < WPB; k++) begin
            word_addr[k] = line_base + 64'(beat) * 64'(BEAT_BYTES) + 64'(4 * k);
            word_off[k]  = '0;
            if (take && !zero_hit && (word_addr[k] >= fetch_pc)) begin
                if (bus_resp[32*k +: 32] == 32'h0) begin
                    zero_hit = 1'b1;
                end else begin
                    word_en[k]  = 1'b1;
                    word_off[k] = n_enq[PTR_W-1:0];
                    n_enq       = n_enq + CNT_W'(1);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; a redirect overrides normal sequencing but still lets
    // an accepted burst finish draining.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (halt_pend)                       state_nx = HALT;
                else if (free_slots >= CNT_W'(IPL))  state_nx = REQ;
            end
            REQ:  if (bus_reqack) state_nx = RESP;
            RESP: begin
                if (bus_respcyc) begin
                    if (beat_last)     state_nx = zero_hit ? HALT : IDLE;
                    else if (zero_hit) state_nx = DRAIN;
                end
            end
            DRAIN: if (bus_respcyc && beat_last) state_nx = halt_pend ? HALT : IDLE;
            default: state_nx = state;
        endcase
        if (redirect) begin
            case (state)
                REQ:         state_nx = bus_reqack ? DRAIN : IDLE;
                RESP, DRAIN: state_nx = (bus_respcyc && beat_last) ? IDLE : DRAIN;
                default:     state_nx = IDLE;
            endcase
        end
    end

    // Bus and decode-side outputs decoded from registered state.
    always_comb begin
        bus_reqcyc  = (state == REQ);
        bus_req     = (state == REQ) ? BUS_DATA_WIDTH'(line_base) : '0;
        bus_respack = ((state == RESP) || (state == DRAIN)) && bus_respcyc;
        inst_valid  = (count != '0);
        inst_bits   = inst_valid ? mem_bits[head] : '0;
        inst_pc     = inst_valid ? mem_pc[head] : '0;
    end

    // Fetch PC, beat counter, halt tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= entry;
            beat      <= '0;
            halt_pend <= 1'b0;
            halted    <= 1'b0;
        end else begin
            if (state == REQ)   beat <= '0;
            else if (beat_fire) beat <= beat_last ? '0 : beat + BEAT_W'(1);
            if (redirect) begin
                fetch_pc  <= redirect_pc;
                halt_pend <= 1'b0;
                halted    <= 1'b0;
            end else begin
                if (take && beat_last) fetch_pc <= line_base + 64'(LINE_BYTES);
                if (zero_hit)          halt_pend <= 1'b1;
                halted <= halt_pend && (count == '0);
            end
        end
    end

    // Queue pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq);
            tail  <= tail + n_enq[PTR_W-1:0];
            count <= count + n_enq - CNT_W'(deq);
        end
    end

    // Queue storage: all kept words of a beat land in consecutive slots.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WPB; k++) begin
            if (word_en[k]) begin
                mem_bits[tail + word_off[k]] <= bus_resp[32*k +: 32];
                mem_pc[tail + word_off[k]]   <= word_addr[k];
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios with a single-process bus responder.
module tb_fetch_queue;
    localparam int unsigned BDW = 64;
    localparam int unsigned TW  = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic [63:0]     entry;
    logic            bus_reqcyc;
    logic [BDW-1:0]  bus_req;
    logic [TW-1:0]   bus_reqtag;
    logic            bus_reqack;
    logic            bus_respcyc;
    logic [BDW-1:0]  bus_resp;
    logic [TW-1:0]   bus_resptag;
    logic            bus_respack;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_bits;
    logic [63:0]     inst_pc;
    logic            redirect;
    logic [63:0]     redirect_pc;
    logic            halted;

    always #5 clk = ~clk;

    fetch_queue #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .LINE_BYTES(64), .QUEUE_DEPTH(32)) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_bits(inst_bits), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
    );

    typedef struct {
        logic [63:0] entry_pc;
        logic [63:0] zero;
        int          rbeat;
        logic [63:0] rpc;
        int          n_pre;
        int          n_inst;
        int          n_req;
        logic [63:0] req0;
        logic [63:0] req1;
        logic [63:0] req2;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] zero_addr;
    int          redir_beat;
    logic [63:0] redir_pc_cfg;
    logic [63:0] got_pc [$];
    logic [31:0] got_bits [$];
    logic [63:0] reqs [$];
    int          beats_acked;
    bit          busy;
    int          beat;
    logic [63:0] base;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a == zero_addr) ? 32'h0 : {16'h0013, a[15:0]};
    endfunction

    // One clock: sample at negedge, then update responder/redirect after posedge.
    task automatic cycle();
        logic        acc_req;
        logic        acc_beat;
        logic [63:0] req_a;
        @(negedge clk);
        if (!reset && inst_valid && inst_ready && !redirect) begin
            got_pc.push_back(inst_pc);
            got_bits.push_back(inst_bits);
        end
        acc_req  = !reset && bus_reqcyc && bus_reqack;
        acc_beat = !reset && bus_respcyc && bus_respack;
        req_a    = 64'(bus_req);
        if (acc_req) begin
            reqs.push_back(req_a);
            chk("reqtag", 64'(bus_reqtag), 64'h1100);
        end
        @(posedge clk);
        #1;
        if (redirect) chk("redir_flush_valid", 64'(inst_valid), 64'h0);
        redirect = 1'b0;
        if (reset) begin
            busy = 1'b0;
            beat = 0;
        end else if (acc_req) begin
            busy = 1'b1;
            beat = 0;
            base = req_a;
        end else if (acc_beat) begin
            beat++;
            beats_acked++;
            if (beat == 8) busy = 1'b0;
        end
        bus_reqack  = !reset && !busy && bus_reqcyc;
        bus_respcyc = busy;
        bus_resp    = busy ? {mem_word(base + 64'(beat * 8 + 4)), mem_word(base + 64'(beat * 8))} : '0;
        if (busy && beat == redir_beat && reqs.size() == 1) begin
            redirect    = 1'b1;
            redirect_pc = redir_pc_cfg;
        end
    endtask

    task automatic clear_logs();
        got_pc.delete();
        got_bits.delete();
        reqs.delete();
        beats_acked = 0;
    endtask

    task automatic do_reset(input logic [63:0] e, input logic [63:0] exp_req);
        reset = 1'b1;
        entry = e;
        redirect = 1'b0;
        cycle();
        cycle();
        chk("rst_reqcyc", 64'(bus_reqcyc), 64'h0);
        chk("rst_req", 64'(bus_req), 64'h0);
        chk("rst_respack", 64'(bus_respack), 64'h0);
        chk("rst_valid", 64'(inst_valid), 64'h0);
        chk("rst_bits", 64'(inst_bits), 64'h0);
        chk("rst_pc", inst_pc, 64'h0);
        chk("rst_halted", 64'(halted), 64'h0);
        clear_logs();
        reset = 1'b0;
        cycle();
        chk("first_reqcyc", 64'(bus_reqcyc), 64'h1);
        chk("first_req", 64'(bus_req), exp_req);
    endtask

    task automatic run_until_halt(input int max);
        int n = 0;
        while (!halted && n < max) begin
            cycle();
            n++;
        end
        chk("halted", 64'(halted), 64'h1);
        repeat (20) cycle();
    endtask

    vec_t vecs [4];

    initial begin
        logic [63:0] er [3];
        logic [63:0] exp_pc;
        int          bad;
        bit          moved;

        vecs[0] = '{64'h1000, 64'h1080, -1, 64'h0,    0, 32, 3, 64'h1000, 64'h1040, 64'h1080};
        vecs[1] = '{64'h1008, 64'h1040, -1, 64'h0,    0, 14, 2, 64'h1000, 64'h1040, 64'h0};
        vecs[2] = '{64'h1000, 64'h2020,  3, 64'h2004, 2,  9, 2, 64'h1000, 64'h2000, 64'h0};
        vecs[3] = '{64'h1000, 64'h1014, -1, 64'h0,    0,  5, 1, 64'h1000, 64'h0,    64'h0};

        reset = 1'b1; entry = '0; redirect = 1'b0; redirect_pc = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        inst_ready = 1'b1; busy = 1'b0; beat = 0; base = '0; beats_acked = 0;
        zero_addr = 64'h0; redir_beat = -1; redir_pc_cfg = '0;

        // Table-driven scenarios: each ends in a zero-word halt.
        for (int s = 0; s < 4; s++) begin
            zero_addr    = vecs[s].zero;
            redir_beat   = vecs[s].rbeat;
            redir_pc_cfg = vecs[s].rpc;
            inst_ready   = 1'b1;
            do_reset(vecs[s].entry_pc, vecs[s].req0);
            run_until_halt(3000);
            chk("n_inst", 64'(got_pc.size()), 64'(vecs[s].n_inst));
            bad = 0;
            for (int i = 0; i < vecs[s].n_inst && i < int'(got_pc.size()); i++) begin
                if (vecs[s].rbeat >= 0 && i >= vecs[s].n_pre)
                    exp_pc = vecs[s].rpc + 64'(4 * (i - vecs[s].n_pre));
                else
                    exp_pc = vecs[s].entry_pc + 64'(4 * i);
                if (got_pc[i] !== exp_pc || got_bits[i] !== {16'h0013, exp_pc[15:0]}) bad++;
            end
            chk("stream_bad", 64'(bad), 64'h0);
            chk("n_req", 64'(reqs.size()), 64'(vecs[s].n_req));
            er = '{vecs[s].req0, vecs[s].req1, vecs[s].req2};
            for (int i = 0; i < vecs[s].n_req && i < int'(reqs.size()); i++)
                chk("req_addr", reqs[i], er[i]);
            chk("beats_acked", 64'(beats_acked), 64'(8 * vecs[s].n_req));
            chk("reqcyc_quiet", 64'(bus_reqcyc), 64'h0);
        end

        // Redirect while halted, with decode ready in the same cycle.
        redir_beat  = -1;
        zero_addr   = 64'h3008;
        clear_logs();
        redirect    = 1'b1;
        redirect_pc = 64'h3000;
        inst_ready  = 1'b1;
        cycle();
        chk("halted_fall", 64'(halted), 64'h0);
        run_until_halt(500);
        chk("hr_n_inst", 64'(got_pc.size()), 64'h2);
        if (got_pc.size() >= 2) begin
            chk("hr_pc0", got_pc[0], 64'h3000);
            chk("hr_pc1", got_pc[1], 64'h3004);
        end
        chk("hr_n_req", 64'(reqs.size()), 64'h1);
        if (reqs.size() >= 1) chk("hr_req", reqs[0], 64'h3000);

        // Backpressure: two lines fill the queue, third request waits for 16 free slots.
        zero_addr  = 64'h9000;
        inst_ready = 1'b0;
        do_reset(64'h1000, 64'h1000);
        moved = 1'b0;
        repeat (60) begin
            cycle();
            if (inst_valid && (inst_pc !== 64'h1000 || inst_bits !== 32'h0013_1000)) moved = 1'b1;
        end
        chk("bp_n_req", 64'(reqs.size()), 64'h2);
        chk("bp_beats", 64'(beats_acked), 64'd16);
        chk("bp_reqcyc", 64'(bus_reqcyc), 64'h0);
        chk("bp_valid", 64'(inst_valid), 64'h1);
        chk("bp_head_stable", 64'(moved), 64'h0);
        chk("bp_no_deq", 64'(got_pc.size()), 64'h0);
        inst_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            cycle();
            if (bus_reqcyc) break;
        end
        chk("bp_third_reqcyc", 64'(bus_reqcyc), 64'h1);
        chk("bp_deq_at_req", 64'(got_pc.size()), 64'd17);
        chk("bp_third_req", 64'(bus_req), 64'h1080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the RISC-V core. It issues line-sized read bursts on the Sysbus and splits each response beat into 32-bit instructions. Instructions are buffered, each with its PC, in a circular queue that feeds decode through a valid/ready handshake. It supports unaligned entry, pipeline redirects with in-flight burst draining, and a zero-word halt.

## Interface
- BUS_DATA_WIDTH, 64: bus beat width in bits; multiple of 32.
- BUS_TAG_WIDTH, 13: Sysbus tag width.
- LINE_BYTES, 64: bytes per burst; BEATS = LINE_BYTES*8/BUS_DATA_WIDTH.
- QUEUE_DEPTH, 32: instruction slots; power of two; must be ≥ IPL = LINE_BYTES/4.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- entry  in  64  start PC, sampled during reset; 4-byte aligned.
- bus_reqcyc  out  1  read request valid.
- bus_req  out  BUS_DATA_WIDTH  line-aligned request address.
- bus_reqtag  out  BUS_TAG_WIDTH  constant `SYSBUS_READ<<12 | `SYSBUS_MEMORY<<8`.
- bus_reqack  in  1  request accepted.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  BUS_DATA_WIDTH  response data.
- bus_resptag  in  BUS_TAG_WIDTH  response tag; ignored.
- bus_respack  out  1  beat consumed.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_bits  out  32  head instruction.
- inst_pc  out  64  head PC.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  64  new PC; 4-byte aligned.
- halted  out  1  zero word seen and queue drained.

## Operation
- Registers:
  - fetch_pc: next instruction PC to fetch.
  - beat counter: 0..BEATS-1.
  - queue: head/tail pointers plus a count of width log2(QUEUE_DEPTH)+1.
- States:
  - IDLE: move to REQ when free slots ≥ IPL and no halt is pending.
  - REQ: bus_reqcyc=1, bus_req = fetch_pc with low log2(LINE_BYTES) bits cleared. Address and tag are held stable until bus_reqack is sampled high, then go to RESP.
  - RESP: bus_respack = bus_respcyc, combinational. Every acked beat is consumed. After the last beat, fetch_pc advances to the next line base and the state returns to IDLE.
  - DRAIN: like RESP, but beats are acked and discarded. After the last beat, go to IDLE, or to HALT if a halt is pending.
  - HALT: no requests are issued. halted=1 once the queue is empty.
- Beat unpacking:
  - Word k occupies bus_resp[32k+31:32k] and has address line_base + beat*BUS_DATA_WIDTH/8 + 4k.
  - Words whose address is below fetch_pc (unaligned entry or redirect target) are discarded.
  - All remaining words of one beat are enqueued in the same cycle, in ascending address order.
- Zero word:
  - A 32'h0 word is never enqueued. It and all later words in the line are dropped, and a halt becomes pending.
  - The remaining beats of the burst are drained. The queued instructions before the zero word are still delivered.
- Dequeue: occurs when inst_valid && inst_ready. Enqueue and dequeue may happen in the same cycle; count changes by (enqueued − dequeued).
- Redirect, any state:
  - Queue flushed (count=0), fetch_pc=redirect_pc, halt cleared.
  - From RESP, or REQ after reqack, go to DRAIN. From REQ before reqack, drop the request and go to IDLE. Otherwise go to IDLE.
  - Redirect wins over enqueue, dequeue and halt detection in the same cycle.
- Pointers wrap modulo QUEUE_DEPTH. Overflow cannot occur, because a request is only issued with ≥ IPL free slots.

## Timing
- Reset values: bus_reqcyc=0, bus_req=0, bus_respack=0, inst_valid=0, inst_bits=0, inst_pc=0, halted=0, queue empty, fetch_pc=entry, state IDLE.
- The first request is asserted in the cycle after the first non-reset edge.
- Reset asserted mid-burst returns the block to reset values at the next edge. Stale beats arriving after reset must be handled by system reset of the bus.
- A beat acked at edge N shows its first instruction on inst_valid after edge N, in cycle N+1. Unpacking is registered; there is no combinational data path from bus to inst_*.
- inst_bits and inst_pc stay stable while inst_valid && !inst_ready.
- After a redirect at edge N: inst_valid=0 in cycle N+1, and the new request is asserted no earlier than N+1, or after the drain completes.
- halted rises the cycle after the queue becomes empty with a halt pending. It falls the cycle after redirect is sampled.

## Test plan
- Aligned run: entry=0x1000, reqack immediate, 8 beats of nonzero data, inst_ready=1 → bus_req=0x1000 then 0x1040; 16 instructions with PCs 0x1000..0x103C in order, low half of each beat first.
- Unaligned entry: entry=0x1008 → request 0x1000; first inst_pc=0x1008; 14 instructions from line 0.
- Backpressure: inst_ready=0, QUEUE_DEPTH=32 → exactly two lines fetched, count=32, bus_reqcyc stays 0. Raise inst_ready → the third request issues only once ≥16 slots are free.
- Zero halt: word at 0x1014 = 0 → instructions 0x1000..0x1010 delivered, beats 3..7 acked, halted=1 after the last dequeue, no further requests.
- Redirect mid-burst: redirect_pc=0x2004 asserted at beat 3 → queue empties next cycle, beats 4..7 acked and dropped, next bus_req=0x2000, first inst_pc=0x2004.
- Redirect during HALT with simultaneous inst_ready → halted clears, fetch resumes at redirect_pc.
